id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised, pipelined instruction-decode stage. Holds the architectural register file (x0 hard-wired to zero), selects and commits write-back data, sign-extends immediates, detects load-use hazards, and registers decoded operands into an ID/EX pipeline register behind a valid/ready handshake with flush. Sits between the IF/ID register and the EX stage. Write-back comes from the WB stage. Hazard inputs come from the EX stage.

## Interface
- XLEN, 32: datapath width; must be ≥32.
- NREG, 32: register count, power of two, ≤32. AW = log2(NREG).
- DBG_REG, 19: index of the register mirrored on dbg_rdata.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  inst/pc valid from IF/ID.
- in_ready  out  1  stage accepts inst/pc this cycle.
- inst  in  32  instruction. rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], each truncated to AW bits.
- pc  in  XLEN  instruction address.
- sext_op  in  3  immediate format select.
- wb_we  in  1  register-file write enable.
- wb_sel  in  2  write-data select: 0 alu_c, 1 pc4, 2 dram_rd, 3 zero.
- wb_rd  in  AW  write index.
- wb_alu_c, wb_pc4, wb_dram_rd  in  XLEN each  write-back candidates.
- wb_wd  out  XLEN  selected write data (combinational).
- ex_is_load  in  1  the instruction in EX is a load.
- ex_rd  in  AW  destination of the instruction in EX.
- flush  in  1  squash the ID/EX register and refuse input.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the ID/EX contents.
- out_rd1, out_rd2, out_ext, out_pc  out  XLEN each  registered operands, immediate and pc.
- out_rd  out  AW  registered destination index.
- dbg_rdata  out  XLEN  current value of register DBG_REG (combinational).

## Operation
- **Register file:** NREG×XLEN. Written on the clock edge when wb_we=1 and wb_rd≠0. Writes to x0 are discarded. Reads of x0 return 0.
- **Read bypass:** if wb_we=1, wb_rd≠0 and wb_rd equals rs1 (or rs2), the read returns wb_wd in the same cycle. The decoded value therefore never lags a same-cycle write-back.
- **Immediate (out_ext):** every format is sign-extended from bit 31 to XLEN, except sext_op 5.
  - sext_op 0 (I): inst[31:20].
  - sext_op 1 (S): {inst[31:25], inst[11:7]}.
  - sext_op 2 (B): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - sext_op 3 (U): {inst[31:12], 12'b0}.
  - sext_op 4 (J): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - sext_op 5: inst[24:20], zero-extended.
  - sext_op 6, 7: result is 0.
- **Hazard:** hazard = ex_is_load & (ex_rd≠0) & (ex_rd==rs1 | ex_rd==rs2). The check always uses both fields, regardless of format.
- **Ready:** in_ready = ~flush & ~hazard & (~out_valid | out_ready).
- **ID/EX register update, in priority order:**
  1. flush: out_valid←0. Data registers are held.
  2. Accept (in_valid & in_ready): load all out_* fields, out_valid←1.
  3. out_ready & out_valid: out_valid←0. This inserts a bubble when a hazard or an empty input blocks the accept.
  4. Otherwise: hold all fields.
- **Scope:** stale operands already held in ID/EX are not corrected by later write-backs. EX forwarding handles that case.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Register-file write latency:
  - A write at edge N is visible to reads from cycle N onward through the bypass.
  - It is visible from the array from cycle N+1.
- A load-use hazard costs exactly 1 bubble, provided EX advances ex_rd/ex_is_load on the following edge.
- Backpressure: when out_valid=1 and out_ready=0, every out_* field holds and in_ready=0.
- Flush: affects the next edge only. An instruction presented with flush=1 is not accepted and must be re-presented.
- Simultaneous flush and wb_we: the register-file write still occurs.
- Reset (asynchronous assert, at any point including mid-stall):
  - All registers cleared to 0.
  - out_valid=0; out_rd1, out_rd2, out_ext, out_pc, out_rd = 0.
  - in_ready follows its equation from reset state: 1 when flush=0 and no hazard.
  - dbg_rdata=0.
- Deassertion is expected to be synchronised externally.

## Test plan
- **Write then read:** wb_we=1, wb_rd=5, wb_sel=0, wb_alu_c=0x1234. Next cycle present inst with rs1=5 (no same-cycle write) → out_rd1=0x1234 one edge after accept.
- **Bypass and x0:**
  - Same cycle: wb_we=1, wb_rd=7, wb_sel=2, wb_dram_rd=0xDEAD; inst rs2=7 → out_rd2=0xDEAD.
  - wb_rd=0, wb_alu_c=0xFFFF → a later read of x0 returns 0.
- **Sext:** inst=0xFFF00093 with sext_op=0 → out_ext=0xFFFFFFFF. inst=0x800000EF with sext_op=4 → out_ext=0xFFF00000. sext_op=3 on inst=0x12345037 → 0x12345000.
- **Load-use:** ex_is_load=1, ex_rd=3; inst rs1=3, in_valid=1, out_ready=1.
  - in_ready=0 and out_valid→0 for 1 cycle.
  - Drop ex_is_load → accepted the next cycle.
- **Backpressure/flush:** with out_valid=1 and out_ready=0 for 3 cycles, out_* stay stable and in_ready=0. Then flush=1 → out_valid=0 after the edge and nothing is accepted in that cycle.
- **Async reset mid-operation:** with out_valid=1 and x19=0x55 (dbg_rdata=0x55), assert rst_n=0 between edges → immediately out_valid=0, dbg_rdata=0 and all out_* fields 0.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// Handshake and operand bus of the decode stage.
// The slave side is the decode stage itself; the master side is the
// surrounding pipeline (IF/ID register upstream, EX stage downstream).
interface id_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  // IF/ID side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [2:0]      sext_op;
  logic            flush;

  // ID/EX side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rd1;
  logic [XLEN-1:0] out_rd2;
  logic [XLEN-1:0] out_ext;
  logic [XLEN-1:0] out_pc;
  logic [AW-1:0]   out_rd;

  modport master (
    output in_valid, inst, pc, sext_op, flush, out_ready,
    input  in_ready, out_valid, out_rd1, out_rd2, out_ext, out_pc, out_rd
  );

  modport slave (
    input  in_valid, inst, pc, sext_op, flush, out_ready,
    output in_ready, out_valid, out_rd1, out_rd2, out_ext, out_pc, out_rd
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined instruction-decode stage: register file with write-back
// bypass, immediate generation, load-use hazard detection and an ID/EX
// register behind a valid/ready handshake with flush.
module id_stage_pipe #(
  parameter int  XLEN    = 32,
  parameter int  NREG    = 32,
  parameter int  DBG_REG = 19,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_stage_pipe_if.slave       bus,
  input  logic                 wb_we,
  input  logic [1:0]           wb_sel,
  input  logic [AW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_alu_c,
  input  logic [XLEN-1:0]      wb_pc4,
  input  logic [XLEN-1:0]      wb_dram_rd,
  output logic [XLEN-1:0]      wb_wd,
  input  logic                 ex_is_load,
  input  logic [AW-1:0]        ex_rd,
  output logic [XLEN-1:0]      dbg_rdata
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC4  = 2'd1,
    WB_DRAM = 2'd2,
    WB_ZERO = 2'd3
  } wb_sel_e;

  localparam logic [AW-1:0] DBG_IDX = AW'(DBG_REG);

  logic [XLEN-1:0] regs [NREG];

  logic [AW-1:0]   rs1, rs2, rd;
  logic            wb_commit;
  logic [XLEN-1:0] rd1_val, rd2_val;
  logic [31:0]     imm32;
  logic [XLEN-1:0] ext_val;
  logic            hazard;
  logic            accept;

  logic            valid_q;
  logic [XLEN-1:0] rd1_q, rd2_q, ext_q, pc_q;
  logic [AW-1:0]   rd_q;

  // Opcode bits (and rs/rd bits above AW when NREG < 32) are not decoded here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^bus.inst;

  assign rs1 = bus.inst[15 +: AW];
  assign rs2 = bus.inst[20 +: AW];
  assign rd  = bus.inst[7  +: AW];

  assign wb_commit = wb_we && (wb_rd != '0);

  // Write-back data select.
  // NOTE: every signal driven in always_comb gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wb_wd = '0;
    unique case (wb_sel_e'(wb_sel))
      WB_ALU:  wb_wd = wb_alu_c;
      WB_PC4:  wb_wd = wb_pc4;
      WB_DRAM: wb_wd = wb_dram_rd;
      WB_ZERO: wb_wd = '0;
      default: wb_wd = '0;
    endcase
  end

  // Register file: one write port, x0 never written so it always reads 0.
  // NOTE: the array is reset because the architectural state must read as
  // zero after reset (including the debug mirror); this forces flops rather
  // than a RAM macro, which is acceptable at NREG <= 32.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_commit) begin
      regs[wb_rd] <= wb_wd;
    end
  end

  // Operand read with same-cycle write-back bypass; x0 reads as zero.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (rs1 != '0) rd1_val = (wb_commit && wb_rd == rs1) ? wb_wd : regs[rs1];
    if (rs2 != '0) rd2_val = (wb_commit && wb_rd == rs2) ? wb_wd : regs[rs2];
  end

  // Immediate generation: build a 32-bit immediate, then sign-extend bit 31.
  // The zero-extended shamt-style format (5) keeps bit 31 clear, so the same
  // signed widening yields a zero extension for it.
  always_comb begin
    imm32 = '0;
    unique case (bus.sext_op)
      3'd0: imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
      3'd1: imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
      3'd2: imm32 = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                     bus.inst[30:25], bus.inst[11:8], 1'b0};
      3'd3: imm32 = {bus.inst[31:12], 12'b0};
      3'd4: imm32 = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                     bus.inst[20], bus.inst[30:21], 1'b0};
      3'd5: imm32 = {27'b0, bus.inst[24:20]};
      default: imm32 = '0;
    endcase
    ext_val = XLEN'($signed(imm32));
  end

  // Load-use hazard: both source fields are always checked, whatever the format.
  assign hazard = ex_is_load && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));

  assign bus.in_ready = !bus.flush && !hazard && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // ID/EX register: flush beats accept beats drain; data holds on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ext_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      rd1_q   <= rd1_val;
      rd2_q   <= rd2_val;
      ext_q   <= ext_val;
      pc_q    <= bus.pc;
      rd_q    <= rd;
    end else if (bus.out_ready && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_rd1   = rd1_q;
  assign bus.out_rd2   = rd2_q;
  assign bus.out_ext   = ext_q;
  assign bus.out_pc    = pc_q;
  assign bus.out_rd    = rd_q;

  // Debug mirror reads the array directly (no bypass).
  assign dbg_rdata = regs[DBG_IDX];

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed write-back, bypass and
// hazard sequences plus a table of immediate-decode vectors.
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            wb_we;
  logic [1:0]      wb_sel;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_alu_c, wb_pc4, wb_dram_rd, wb_wd;
  logic            ex_is_load;
  logic [AW-1:0]   ex_rd;
  logic [XLEN-1:0] dbg_rdata;

  int n_compared = 0;
  int n_mismatch = 0;

  id_stage_pipe_if #(.XLEN(XLEN), .AW(AW)) bus ();

  id_stage_pipe #(.XLEN(XLEN), .NREG(32), .DBG_REG(19)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_rd      (wb_rd),
    .wb_alu_c   (wb_alu_c),
    .wb_pc4     (wb_pc4),
    .wb_dram_rd (wb_dram_rd),
    .wb_wd      (wb_wd),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .dbg_rdata  (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  op;
    logic [31:0] exp_ext;
    logic [4:0]  exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] val);
    wb_we      = we;
    wb_rd      = rd;
    wb_sel     = sel;
    wb_alu_c   = val;
    wb_pc4     = val;
    wb_dram_rd = val;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.inst = '0; bus.pc = '0; bus.sext_op = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    wb_set(1'b0, 5'd0, 2'd0, 32'h0);
    ex_is_load = 1'b0; ex_rd = '0;

    vecs[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 5'd1};
    vecs[1] = '{32'h800000EF, 3'd4, 32'hFFF00000, 5'd1};
    vecs[2] = '{32'h12345037, 3'd3, 32'h12345000, 5'd0};
    vecs[3] = '{32'h80000080, 3'd1, 32'hFFFFF801, 5'd1};
    vecs[4] = '{32'h80000080, 3'd2, 32'hFFFFF800, 5'd1};
    vecs[5] = '{32'h7FF00013, 3'd0, 32'h000007FF, 5'd0};
    vecs[6] = '{32'hFFFFFFFF, 3'd5, 32'h0000001F, 5'd31};
    vecs[7] = '{32'hFFFFFFFF, 3'd6, 32'h00000000, 5'd31};
    vecs[8] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 5'd31};

    // Reset state
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_dbg", 64'(dbg_rdata), 64'd0);
    check("rst_out_rd1", 64'(bus.out_rd1), 64'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // Preload x3 and check the write-data mux, including the zero select
    wb_set(1'b1, 5'd3, 2'd0, 32'hABC);
    #1 check("wd_alu", 64'(wb_wd), 64'hABC);
    wb_sel = 2'd3;
    #1 check("wd_zero", 64'(wb_wd), 64'd0);
    wb_sel = 2'd0;
    tick();

    // Write then read (no same-cycle write)
    wb_set(1'b1, 5'd5, 2'd0, 32'h1234);
    tick();
    wb_we = 1'b0;
    bus.inst = 32'h00028000; bus.pc = 32'h40; bus.sext_op = 3'd0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 check("wr_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("wr_out_valid", 64'(bus.out_valid), 64'd1);
    check("wr_out_rd1", 64'(bus.out_rd1), 64'h1234);
    check("wr_out_pc", 64'(bus.out_pc), 64'h40);

    // Same-cycle bypass to rs2
    wb_set(1'b1, 5'd7, 2'd2, 32'hDEAD);
    bus.inst = 32'h00700000; bus.pc = 32'h100; bus.sext_op = 3'd5;
    #1 check("wd_dram", 64'(wb_wd), 64'hDEAD);
    tick();
    check("byp_out_rd2", 64'(bus.out_rd2), 64'hDEAD);
    check("byp_out_ext", 64'(bus.out_ext), 64'd7);

    // Write to x0 in the same cycle as a read of x0; x7 now from the array
    wb_set(1'b1, 5'd0, 2'd0, 32'hFFFF);
    tick();
    check("x0_byp_rd1", 64'(bus.out_rd1), 64'd0);
    check("x7_array_rd2", 64'(bus.out_rd2), 64'hDEAD);
    wb_we = 1'b0;
    tick();
    check("x0_later_rd1", 64'(bus.out_rd1), 64'd0);

    // Immediate decode table, back-to-back accepts
    for (int i = 0; i < 9; i++) begin
      bus.inst = vecs[i].inst;
      bus.sext_op = vecs[i].op;
      bus.pc = 32'h1000 + 32'(i * 4);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("vec%0d_ext", i), 64'(bus.out_ext), 64'(vecs[i].exp_ext));
      check($sformatf("vec%0d_rd", i), 64'(bus.out_rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_pc", i), 64'(bus.out_pc), 64'h1000 + 64'(i * 4));
    end

    // Hazard corner cases (combinational in_ready)
    ex_is_load = 1'b1; ex_rd = 5'd3;
    bus.inst = 32'h00300000;
    #1 check("haz_rs2", 64'(bus.in_ready), 64'd0);
    ex_rd = 5'd4;
    #1 check("haz_other_rd", 64'(bus.in_ready), 64'd1);
    ex_rd = 5'd0; bus.inst = 32'h00000000;
    #1 check("haz_x0", 64'(bus.in_ready), 64'd1);

    // Load-use: one bubble, then accepted once EX advances
    ex_rd = 5'd3;
    bus.inst = 32'h00018000; bus.pc = 32'h2000; bus.sext_op = 3'd0;
    #1 check("lu_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("lu_bubble", 64'(bus.out_valid), 64'd0);
    ex_is_load = 1'b0;
    #1 check("lu_in_ready_after", 64'(bus.in_ready), 64'd1);
    tick();
    check("lu_accept_valid", 64'(bus.out_valid), 64'd1);
    check("lu_accept_rd1", 64'(bus.out_rd1), 64'hABC);
    check("lu_accept_pc", 64'(bus.out_pc), 64'h2000);

    // Backpressure for 3 cycles
    bus.out_ready = 1'b0;
    bus.inst = 32'h00028000; bus.pc = 32'h3000;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
      tick();
      check($sformatf("bp%0d_valid", c), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp%0d_pc", c), 64'(bus.out_pc), 64'h2000);
      check($sformatf("bp%0d_rd1", c), 64'(bus.out_rd1), 64'hABC);
    end

    // Flush together with a write-back to x19
    bus.flush = 1'b1;
    wb_set(1'b1, 5'd19, 2'd1, 32'h55);
    #1 check("fl_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.flush = 1'b0; wb_we = 1'b0;
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_pc_held", 64'(bus.out_pc), 64'h2000);
    check("fl_dbg", 64'(dbg_rdata), 64'h55);

    // Re-present after flush: accepted even with out_ready low
    #1 check("post_fl_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("post_fl_valid", 64'(bus.out_valid), 64'd1);
    check("post_fl_rd1", 64'(bus.out_rd1), 64'h1234);
    check("post_fl_pc", 64'(bus.out_pc), 64'h3000);
    bus.in_valid = 1'b0;

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_dbg", 64'(dbg_rdata), 64'd0);
    check("ar_rd1", 64'(bus.out_rd1), 64'd0);
    check("ar_rd2", 64'(bus.out_rd2), 64'd0);
    check("ar_ext", 64'(bus.out_ext), 64'd0);
    check("ar_pc", 64'(bus.out_pc), 64'd0);
    check("ar_rd", 64'(bus.out_rd), 64'd0);
    check("ar_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
